// File: rtl/add32_pkg.sv
// Shared definitions for the sequential slice adder: slice width, FSM states
// and operation encoding.
package add32_pkg;

    localparam int SLICE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add8_cla.sv
// Combinational 8-bit carry-lookahead slice: sum and carry-out of a + b + cin.
module add8_cla
    import add32_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is the flattened generate/propagate product, not a ripple chain.
    always_comb begin
        logic w_acc;
        logic w_pp;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SLICE_W; i++) begin
            w_acc = w_g[i];
            w_pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & w_g[j]);
                w_pp  = w_pp & w_p[j];
            end
            w_c[i+1] = w_acc | (w_pp & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
    assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/add32_seq.sv
// Sequential add/sub: one 8-bit slice per RUN cycle through add8_cla.
// Optional flags (carry/overflow/zero) are built only with ADD32_SEQ_FLAGS_EN.
module add32_seq
    import add32_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*SLICES-1:0] op_a,
    input  logic [SLICE_W*SLICES-1:0] op_b,
    input  logic                      op_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*SLICES-1:0] result,
    output logic                      flag_c,
    output logic                      flag_v,
    output logic                      flag_z,
    output logic [1:0]                o_dbg_state
);

    localparam int DW    = SLICE_W * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.

    state_t             r_state;
    state_t             w_state_next;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic [DW-1:0]      r_result;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic               w_accept;
    logic               w_last;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic [DW-1:0]      w_result_next;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);
    assign w_sa     = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_sb     = r_b[r_idx*SLICE_W +: SLICE_W];

    add8_cla u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_result_next = r_result;
        w_result_next[r_idx*SLICE_W +: SLICE_W] = w_sum;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        o_dbg_state = r_state;
    end

    // Subtraction is a + ~b + 1: b is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= op_a;
                        r_b     <= (op_sub == OP_SUB) ? ~op_b : op_b;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    r_idx    <= w_last ? '0 : r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

`ifdef ADD32_SEQ_FLAGS_EN
    logic r_flag_c;
    logic r_flag_v;
    logic r_flag_z;

    // Flags are captured on the edge that writes the top slice, with the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_last) begin
            r_flag_c <= w_cout;
            r_flag_v <= (r_a[DW-1] == r_b[DW-1]) & (w_sum[SLICE_W-1] != r_a[DW-1]);
            r_flag_z <= (w_result_next == '0);
        end
    end

    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
    assign flag_z = r_flag_z;
`else
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
    assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_add32_seq.sv
// Scoreboard bench for add32_seq: directed vectors, decoupled monitor, stall and
// mid-operation reset scenarios. Expected flags follow ADD32_SEQ_FLAGS_EN.
module tb_add32_seq;
    import add32_pkg::*;

    localparam int SLICES = 4;
    localparam int DW     = SLICE_W * SLICES;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          flag_c;
    logic          flag_v;
    logic          flag_z;
    logic [1:0]    o_dbg_state;

    add32_seq #(.SLICES(SLICES)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sub      (op_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_z      (flag_z),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW+2:0] exp_q[$];
    int            acc_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic          prev_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [2:0] exp_flags(input logic c, input logic v, input logic z);
`ifdef ADD32_SEQ_FLAGS_EN
        return {c, v, z};
`else
        return {c, v, z} & 3'b000;
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [DW+2:0] e;
        if (rstn && out_valid && !prev_ov) begin
            if (acc_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
            else check("latency", 64'(cyc - acc_q.pop_front()), 64'(SLICES));
        end
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e[DW-1:0]);
                check("flags_cvz", {flag_c, flag_v, flag_z}, e[DW+2:DW]);
            end
        end
        prev_ov = rstn & out_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                        input logic [DW-1:0] res, input logic c, input logic v, input logic z);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1'b1);
            return;
        end
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        exp_q.push_back({exp_flags(c, v, z), res});
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        op_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drained();
        int guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            guard;
        logic          seen_ov;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = OP_ADD;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flags", {flag_c, flag_v, flag_z}, 3'b000);
        check("rst_state", o_dbg_state, 2'(IDLE));
        rstn = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1'b1);

        send(32'h0000_00FF, 32'h0000_0001, OP_ADD, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        send(32'h0000_0007, 32'h0000_0007, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, OP_ADD, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        wait_drained();

        // Consumer stall: DONE must hold result/flags and refuse new operands.
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reach_done", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_result", result, 32'h0);
            check("stall_flags", {flag_c, flag_v, flag_z}, exp_flags(1'b1, 1'b0, 1'b1));
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            in_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_stall_out_valid", out_valid, 1'b0);
        check("post_stall_in_ready", in_ready, 1'b1);
        check("post_stall_queue", 64'(exp_q.size()), 64'd0);

        // Reset pulse while RUN is on slice index 2: operation aborted.
        @(negedge clk);
        op_a     = 32'h0000_00FF;
        op_b     = 32'h0000_0001;
        op_sub   = OP_ADD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_flags", {flag_c, flag_v, flag_z}, 3'b000);
        check("abort_state", o_dbg_state, 2'(IDLE));
        @(negedge clk);
        rstn    = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_ov = seen_ov | out_valid;
        end
        check("abort_no_out_valid", seen_ov, 1'b0);

        send(32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        wait_drained();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
